// File: rtl/arbiter2_wb8.sv
// Two-master round-robin Wishbone arbiter (8-bit data, 32-bit address), CYC-granular grants.
// Optional strobe watchdog enabled by defining ARBITER_TIMEOUT_EN.
module arbiter2_wb8 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [7:0]  M0_DAT_I,
  output logic [7:0]  M0_DAT_O,
  output logic        M0_ACK_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [7:0]  M1_DAT_I,
  output logic [7:0]  M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [7:0]  S_DAT_O,
  input  logic [7:0]  S_DAT_I,
  input  logic        S_ACK_I,
  output logic [1:0]  O_grant,
  output logic        O_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t     r_state;
  logic       r_last;   // index of the master most recently granted
  logic [1:0] r_grant;

  // Grant FSM: owner keeps the bus for its whole CYC, ties go to the master that was not last.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (M0_CYC_I && (!M1_CYC_I || r_last)) begin
            r_state <= ST_GNT0;
            r_grant <= 2'b01;
          end else if (M1_CYC_I) begin
            r_state <= ST_GNT1;
            r_grant <= 2'b10;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end
        end
        ST_GNT0: begin
          if (!M0_CYC_I) begin
            r_last <= 1'b0;
            if (M1_CYC_I) begin
              r_state <= ST_GNT1;
              r_grant <= 2'b10;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= 2'b00;
            end
          end
        end
        ST_GNT1: begin
          if (!M1_CYC_I) begin
            r_last <= 1'b1;
            if (M0_CYC_I) begin
              r_state <= ST_GNT0;
              r_grant <= 2'b01;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= 2'b00;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign O_grant = r_grant;

`ifdef ARBITER_TIMEOUT_EN
  logic [7:0] r_wd_cnt;
  logic       w_own_cyc;
  logic       w_own_stb;
  logic       w_fire;

  // Select the owner's CYC/STB for the watchdog.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    case (r_state)
      ST_GNT0: begin
        w_own_cyc = M0_CYC_I;
        w_own_stb = M0_STB_I;
      end
      ST_GNT1: begin
        w_own_cyc = M1_CYC_I;
        w_own_stb = M1_STB_I;
      end
      default: begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
      end
    endcase
  end

  // Fires on the stall cycle whose 1-based count reaches TIMEOUT_CYCLES.
  assign w_fire = w_own_stb & ~S_ACK_I & ~RST_I & ((r_wd_cnt + 8'd1) == LP_TIMEOUT);

  // Stall counter; an owner dropping CYC is exactly a grant change at the next edge.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_wd_cnt <= 8'd0;
    end else if (!w_own_cyc || !w_own_stb || S_ACK_I || w_fire) begin
      r_wd_cnt <= 8'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 8'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^LP_TIMEOUT;
`endif

  // Downstream mux and ACK qualification; read data is broadcast to both masters.
  always_comb begin
    S_CYC_O   = 1'b0;
    S_STB_O   = 1'b0;
    S_WE_O    = 1'b0;
    S_ADR_O   = 32'h0000_0000;
    S_DAT_O   = 8'h00;
    M0_ACK_O  = 1'b0;
    M1_ACK_O  = 1'b0;
    M0_DAT_O  = S_DAT_I;
    M1_DAT_O  = S_DAT_I;
    O_timeout = 1'b0;
    case (r_state)
      ST_GNT0: begin
        S_CYC_O  = M0_CYC_I;
        S_STB_O  = M0_STB_I;
        S_WE_O   = M0_WE_I;
        S_ADR_O  = M0_ADR_I;
        S_DAT_O  = M0_DAT_I;
        M0_ACK_O = S_ACK_I & ~RST_I;
      end
      ST_GNT1: begin
        S_CYC_O  = M1_CYC_I;
        S_STB_O  = M1_STB_I;
        S_WE_O   = M1_WE_I;
        S_ADR_O  = M1_ADR_I;
        S_DAT_O  = M1_DAT_I;
        M1_ACK_O = S_ACK_I & ~RST_I;
      end
      default: begin
        S_CYC_O = 1'b0;
      end
    endcase
`ifdef ARBITER_TIMEOUT_EN
    if (w_fire) begin
      S_STB_O   = 1'b0;
      O_timeout = 1'b1;
      if (r_state == ST_GNT1) begin
        M1_ACK_O = 1'b1;
        M1_DAT_O = 8'hFF;
      end else begin
        M0_ACK_O = 1'b1;
        M0_DAT_O = 8'hFF;
      end
    end else begin
      O_timeout = 1'b0;
    end
`endif
  end

endmodule

// File: doc/arbiter2_wb8.md
# arbiter2_wb8

Two-master arbiter for the 8-bit Wishbone bus. Shares one downstream bus (the address decoder feeding ROM, SRAM and I/O slaves) between the CPU and a second bus master, such as a DMA or video fetch engine. Grants are round-robin at Wishbone cycle granularity (CYC). An optional watchdog terminates strobes that a slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: strobe cycles without ACK before the watchdog fires (1..255; 8-bit counter).

Ports:
- CLK_I  in  1  single bus clock.
- RST_I  in  1  synchronous reset, active-high.
- M0_CYC_I, M0_STB_I, M0_WE_I  in  1 each  master 0 (CPU) cycle, strobe, write enable.
- M0_ADR_I  in  32  master 0 address.
- M0_DAT_I  in  8  master 0 write data.
- M0_DAT_O  out  8  master 0 read data.
- M0_ACK_O  out  1  master 0 acknowledge.
- M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I, M1_DAT_O, M1_ACK_O: same set for master 1, same widths.
- S_CYC_O, S_STB_O, S_WE_O  out  1 each  to the downstream decoder.
- S_ADR_O  out  32  downstream address.
- S_DAT_O  out  8  downstream write data.
- S_DAT_I  in  8  downstream read data.
- S_ACK_I  in  1  downstream acknowledge.
- O_grant  out  2  one-hot current grant ({M1,M0}); 2'b00 when idle.
- O_timeout  out  1  one-cycle pulse when the watchdog fires (0 when the watchdog is compiled out).

## Operation
- States: IDLE, GNT0, GNT1. A registered `last` bit records the most recently granted master.
- IDLE:
  - Only M0_CYC_I high: go to GNT0.
  - Only M1_CYC_I high: go to GNT1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
- GNTx while Mx_CYC_I stays high: remain in GNTx.
- GNTx when Mx_CYC_I drops:
  - Other master's CYC high: go directly to the other GNT.
  - Otherwise: go to IDLE.
  - `last` is set to x on leaving GNTx.
- Grant is never revoked while the owner holds CYC. A master may run back-to-back strobes (read-modify-write, burst) under one CYC.
- Granted state: S_CYC_O, S_STB_O, S_WE_O, S_ADR_O and S_DAT_O are combinationally muxed from the granted master.
- IDLE: S_CYC_O = S_STB_O = S_WE_O = 0; S_ADR_O and S_DAT_O = 0.
- Mx_ACK_O = S_ACK_I & (grant == x). The non-granted master always sees ACK 0.
- M0_DAT_O = M1_DAT_O = S_DAT_I (broadcast). Only the ACK is qualified.
- Reset, including mid-transfer: state IDLE, `last` = 1 so master 0 wins the first tie, watchdog counter 0. The in-flight transfer is abandoned and no ACK is issued.
- Reset values: all S_* outputs 0, Mx_ACK_O 0, O_grant 00, O_timeout 0.

## Timing
- Grant is registered: a request raised in IDLE at edge n sees S_CYC_O/S_STB_O high after edge n+1, so arbitration adds one cycle.
- Handover GNTx to GNTy: Mx_CYC_I low at edge n gives S_* from My after edge n+1. There is no idle bubble.
- ACK passes through combinationally, zero added latency. Slave-side single-cycle ACK gives master-side single-cycle ACK.
- Simultaneous drop of Mx CYC and rise of My CYC on the same edge: treated as a handover.
- CYC high with STB low: grant is held and S_STB_O is 0.

## Configuration
Macro ARBITER_TIMEOUT_EN.

Defined:
- An 8-bit counter clears on RST_I, on any grant change, on S_ACK_I, or when the granted STB is low.
- It increments each cycle the granted STB is high and S_ACK_I is low.
- When the count equals TIMEOUT_CYCLES, in that same cycle:
  - the granted Mx_ACK_O is forced to 1;
  - Mx_DAT_O is forced to 8'hFF;
  - S_STB_O is forced to 0;
  - O_timeout pulses;
  - the counter clears next edge.
- The grant is held, so the master sees a normal completed transfer.

Not defined:
- No counter logic.
- O_timeout tied to 0.
- A missing ACK stalls the bus indefinitely.

## Test plan
- Reset, then M0 single read at 0xFFFFF004 with the slave acking one cycle after S_STB_O and S_DAT_I = 0x5A:
  - O_grant = 01 one cycle after M0_CYC_I;
  - M0_ACK_O high for one cycle with M0_DAT_O = 0x5A;
  - M1_ACK_O stays 0.
- Both CYC raised together immediately after reset:
  - GNT0 first;
  - M0 drops CYC, then GNT1 on the next edge with no IDLE cycle;
  - repeat with both requesting: GNT0 again (alternation).
- M0 holds CYC across 3 back-to-back writes (0x11, 0x22, 0x33) while M1 requests:
  - M1 is not granted until M0 drops CYC;
  - S_DAT_O shows 0x11, 0x22, 0x33 in order.
- RST_I asserted for one cycle while in GNT1 mid-strobe:
  - next cycle O_grant = 00, S_CYC_O = 0, no ACK to M1;
  - M0 and M1 requesting together afterwards gives GNT0.
- With ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, M1 strobes and the slave never acks:
  - on the 4th stall cycle M1_ACK_O = 1, M1_DAT_O = 0xFF, O_timeout = 1 for one cycle, S_STB_O = 0.
- Same stimulus without the macro: M1_ACK_O stays 0 for 300 cycles and O_timeout stays 0.
